// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART state encoding and bit-period helper.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } uart_state_t;

    // Master-clock cycles per serial bit (integer division).
    function automatic int unsigned pulse_width(input int unsigned clk_freq,
                                                input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_if
// Brief   : Received-byte strobe bundle between uart_rx and its consumer.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_rx_if #(
    parameter int NUM_BITS = 8
);
    logic [NUM_BITS-1:0] rx_byte;
    logic                rx_valid;
    logic                frame_error;
    logic                busy;

    modport master (
        output rx_byte,
        output rx_valid,
        output frame_error,
        output busy
    );

    modport slave (
        input rx_byte,
        input rx_valid,
        input frame_error,
        input busy
    );
endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module  : sync_2ff
// Brief   : Two-flop synchronizer with configurable reset value.
// Revision: 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int              WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Brief   : Oversampling 8N1 UART receiver with mid-bit sampling.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int NUM_BITS        = 8,
    parameter int BAUD_RATE       = 115200,
    parameter int MASTER_CLK_FREQ = 100_000_000
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic rx_serial,
    uart_rx_if.master rx_if
);
    localparam int unsigned c_PULSE_WIDTH      = pulse_width(MASTER_CLK_FREQ, BAUD_RATE);
    localparam int unsigned c_HALF_PULSE_WIDTH = c_PULSE_WIDTH / 2;
    localparam int          c_CNT_W = (c_PULSE_WIDTH > 1) ? $clog2(c_PULSE_WIDTH) : 1;
    localparam int          c_BIT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    localparam logic [c_CNT_W-1:0] c_FULL_LAST = c_CNT_W'(c_PULSE_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_HALF_PULSE_WIDTH - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST  = c_BIT_W'(NUM_BITS - 1);

    logic                w_rx_s;
    uart_state_t         r_state;
    logic [c_CNT_W-1:0]  r_pulse_count;
    logic [c_BIT_W-1:0]  r_bit_count;
    logic [NUM_BITS-1:0] r_shift;
    logic [NUM_BITS-1:0] r_rx_byte;
    logic                r_rx_valid;
    logic                r_frame_error;

    // Idle-high line, so the synchronizer resets to 1 to avoid a false start.
    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (rx_serial),
        .o_q     (w_rx_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_pulse_count <= '0;
            r_bit_count   <= '0;
            r_shift       <= '0;
            r_rx_byte     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_pulse_count <= '0;
                    r_bit_count   <= '0;
                    if (!w_rx_s) r_state <= START;
                end
                START: begin
                    if (r_pulse_count == c_HALF_LAST) begin
                        r_pulse_count <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        r_state       <= w_rx_s ? IDLE : DATA;
                    end else begin
                        r_pulse_count <= r_pulse_count + 1'b1;
                    end
                end
                DATA: begin
                    if (r_pulse_count == c_FULL_LAST) begin
                        r_pulse_count        <= '0;
                        r_shift[r_bit_count] <= w_rx_s;
                        if (r_bit_count == c_BIT_LAST) begin
                            r_bit_count <= '0;
                            r_state     <= STOP;
                        end else begin
                            r_bit_count <= r_bit_count + 1'b1;
                        end
                    end else begin
                        r_pulse_count <= r_pulse_count + 1'b1;
                    end
                end
                STOP: begin
                    if (r_pulse_count == c_FULL_LAST) begin
                        r_pulse_count <= '0;
                        if (w_rx_s) begin
                            r_rx_byte  <= r_shift;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_frame_error <= 1'b1;
                        end
                        r_state <= CLEANUP;
                    end else begin
                        r_pulse_count <= r_pulse_count + 1'b1;
                    end
                end
                CLEANUP: begin
                    // Hold here through a break so a low line cannot re-trigger.
                    if (w_rx_s) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rx_if.rx_byte     = r_rx_byte;
    assign rx_if.rx_valid    = r_rx_valid;
    assign rx_if.frame_error = r_frame_error;
    assign rx_if.busy        = (r_state != IDLE);
endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1 by default, paired with the team's `uart_tx` on the same UART link. It oversamples `rx_serial` with the master clock and validates the start bit at mid-bit. It samples each data bit (LSB first) and the stop bit at mid-bit, then presents the received byte with a one-cycle valid strobe. It sits between the board RX pin and downstream logic, such as a command parser for the ADT7420 readout path.

## Interface
- `NUM_BITS`, 8, data bits per frame.
- `BAUD_RATE`, 115200, line rate in bit/s.
- `MASTER_CLK_FREQ`, 100_000_000, `clk` frequency in Hz.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_serial`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `rx_byte`  out  NUM_BITS  last good byte; holds until the next good frame.
- `rx_valid`  out  1  one-cycle strobe: `rx_byte` has just been updated.
- `frame_error`  out  1  one-cycle strobe: stop bit was sampled low.
- `busy`  out  1  high while a frame is being received (state ≠ IDLE).

## Operation
- Derived constants:
  - `PULSE_WIDTH = MASTER_CLK_FREQ / BAUD_RATE` (integer division; 868 at defaults).
  - `HALF_PULSE_WIDTH = PULSE_WIDTH / 2` (434 at defaults).
  - Counter widths are `$clog2` of these.
- `rx_serial` passes through a 2-flop synchronizer, reset value 1. All decisions use the synchronized signal `rx_s`.
- States are IDLE, START, DATA, STOP, CLEANUP.
  - **IDLE:** `pulse_count` = 0 and `bit_count` = 0. When `rx_s` = 0, go to START.
  - **START:** count `pulse_count` up to `HALF_PULSE_WIDTH-1`.
    - At that count, if `rx_s` = 1 the low pulse was a glitch: go back to IDLE, with no strobes.
    - Otherwise clear `pulse_count` and go to DATA.
  - **DATA:** count `pulse_count` up to `PULSE_WIDTH-1`.
    - At that count, shift `rx_s` into the shift register at position `bit_count` (LSB first) and clear `pulse_count`.
    - If `bit_count` < NUM_BITS-1, increment `bit_count`; else clear it and go to STOP.
  - **STOP:** count up to `PULSE_WIDTH-1`, then sample `rx_s`.
    - If 1: load `rx_byte` from the shift register and pulse `rx_valid`.
    - If 0: pulse `frame_error` and leave `rx_byte` unchanged.
    - Either way, go to CLEANUP.
  - **CLEANUP:** stay until `rx_s` = 1, then go to IDLE. This prevents a break or held-low line from re-triggering reception. The state lasts a minimum of 1 cycle.
- Undefined state encodings go to IDLE.
- There is no back-pressure. A consumer that misses `rx_valid` loses the strobe; `rx_byte` still holds the value until the next good frame.

## Timing
- Reset (`reset_n` low) asynchronously forces:
  - state = IDLE;
  - `rx_byte` = 0, `rx_valid` = 0, `frame_error` = 0, `busy` = 0;
  - both synchronizer flops = 1, all counters = 0.
- Reset in mid-frame aborts the frame with no strobe. After release, reception restarts only on a new falling edge seen in IDLE.
- Synchronizer latency is 2 cycles from a `rx_serial` edge to `rx_s`.
- Define t0 as the cycle in which IDLE sees `rx_s` = 0; the state is START from t0+1.
  - `rx_valid` or `frame_error` is high in exactly one cycle: t0 + `HALF_PULSE_WIDTH` + (NUM_BITS+1)·`PULSE_WIDTH` + 1.
  - At defaults that is t0 + 8247.
- `rx_valid` and `frame_error` are mutually exclusive; both are registered outputs.
- `busy` rises at t0+1 and falls in the cycle after CLEANUP exits.
- Back-to-back frames: a start bit that immediately follows the stop bit is accepted. CLEANUP exits while the line is still high, because the mid-bit stop sample leaves half a bit time of margin.

## Structure
- Package `uart_pkg`:
  - `uart_state_t` enum {IDLE, START, DATA, STOP, CLEANUP};
  - `pulse_width(clk_freq, baud)` function.
  - Both are shared with `uart_tx` for consistency.
- Sub-module `sync_2ff` (width 1, reset value parameter) for the input synchronizer; it is reusable elsewhere.

## Test plan
Bench parameters: `MASTER_CLK_FREQ` = 1_000_000, `BAUD_RATE` = 100_000, so `PULSE_WIDTH` = 10 and `HALF_PULSE_WIDTH` = 5.
- **Reset:** drive `reset_n` = 0 with `rx_serial` = 1 → all outputs are 0 and `busy` = 0. After release, 50 idle cycles → no strobes.
- **Single byte:** drive frame 0xA5 at 10 cycles/bit → `rx_valid` is high for exactly 1 cycle at t0 + 96, `rx_byte` = 0xA5, and `frame_error` stays 0.
- **Glitch rejection:** 3-cycle low pulse on an idle line → `busy` pulses briefly, then returns to 0 with no strobes and `rx_byte` unchanged.
- **Framing error:** frame 0x3C with the stop bit driven low, then the line is held low for 40 cycles and released → `frame_error` pulses once, `rx_byte` keeps its old value, and `busy` stays high until the line goes high.
- **Back-to-back:** frames 0x00, 0xFF, 0x55 sent with no idle gap → three `rx_valid` pulses in order with the matching bytes.
- **Reset mid-frame:** assert `reset_n` during bit 4 of 0x81, release, then send 0x42 → no strobe for the aborted frame, and `rx_byte` = 0x42 with a single `rx_valid`.
